// File: rtl/fix_parser_delim_detect.sv
// Purpose : FIX stream delimiter detector; tags each 32-bit word with SOH/'=' positions and parser state.
// Latency : 1 cycle; a word accepted on cycle N is presented on the outputs at cycle N+1.
// Backpr. : single-entry output register; ready_o = !valid_o || ready_i, so outputs hold while stalled.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         abort current message: drop held word, parser back to tag state, clear field count
//   data_i/valid_i  input word (byte 3 earliest in stream) and its valid; ready_o is its accept
//   data_o          registered copy of the accepted word
//   soh_o, sep_o    byte index of earliest SOH / separator in data_o, 3'b111 when absent
//   tag_status_o    parser was inside a tag when data_o started
//   value_status_o  parser was inside a value when data_o started
//   err_multi_o     data_o holds more than one SOH or more than one separator
//   field_cnt_o     saturating count of SOH bytes accepted since reset/flush
//   valid_o/ready_i output handshake
module fix_parser_delim_detect #(
  parameter logic [7:0] SOH_CHAR = 8'h01,
  parameter logic [7:0] SEP_CHAR = 8'h3D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic [2:0]  soh_o,
  output logic [2:0]  sep_o,
  output logic        tag_status_o,
  output logic        value_status_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_multi_o,
  output logic [15:0] field_cnt_o
);

  typedef enum logic {
    S_TAG   = 1'b0,
    S_VALUE = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic [3:0]  soh_hit;
  logic [3:0]  sep_hit;
  logic [2:0]  soh_num;
  logic [2:0]  sep_num;
  logic [2:0]  soh_idx;
  logic [2:0]  sep_idx;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_next;

  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;

  // Earliest byte in the stream sits at the highest index.
  function automatic logic [2:0] earliest_idx(input logic [3:0] hit);
    logic [2:0] idx;
    idx = 3'b111;
    if (hit[3])      idx = 3'd3;
    else if (hit[2]) idx = 3'd2;
    else if (hit[1]) idx = 3'd1;
    else if (hit[0]) idx = 3'd0;
    return idx;
  endfunction

  always_comb begin
    soh_hit = '0;
    sep_hit = '0;
    for (int k = 0; k < 4; k++) begin
      soh_hit[k] = (data_i[8*k +: 8] == SOH_CHAR);
      sep_hit[k] = (data_i[8*k +: 8] == SEP_CHAR);
    end
  end

  assign soh_num = {2'b00, soh_hit[0]} + {2'b00, soh_hit[1]} +
                   {2'b00, soh_hit[2]} + {2'b00, soh_hit[3]};
  assign sep_num = {2'b00, sep_hit[0]} + {2'b00, sep_hit[1]} +
                   {2'b00, sep_hit[2]} + {2'b00, sep_hit[3]};
  assign soh_idx = earliest_idx(soh_hit);
  assign sep_idx = earliest_idx(sep_hit);

  assign cnt_sum  = {1'b0, field_cnt_o} + {14'b0, soh_num};
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // Next state follows the latest delimiter (lowest index). Scanning from byte 3
  // down to byte 0 lets the last match win. SOH is checked first so it takes
  // precedence if both characters are configured to the same value.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_TAG;
    end else if (accept) begin
      for (int k = 3; k >= 0; k--) begin
        if (soh_hit[k])      state_d = S_TAG;
        else if (sep_hit[k]) state_d = S_VALUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_TAG;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o        <= 1'b0;
      data_o         <= '0;
      soh_o          <= 3'b111;
      sep_o          <= 3'b111;
      tag_status_o   <= 1'b1;
      value_status_o <= 1'b0;
      err_multi_o    <= 1'b0;
      field_cnt_o    <= '0;
    end else if (flush_i) begin
      // Flush beats a simultaneous accept and ignores downstream backpressure.
      valid_o     <= 1'b0;
      field_cnt_o <= '0;
    end else if (accept) begin
      valid_o        <= 1'b1;
      data_o         <= data_i;
      soh_o          <= soh_idx;
      sep_o          <= sep_idx;
      tag_status_o   <= (state_q == S_TAG);
      value_status_o <= (state_q == S_VALUE);
      err_multi_o    <= (soh_num > 3'd1) || (sep_num > 3'd1);
      field_cnt_o    <= cnt_next;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fix_parser_delim_detect.sv
module tb_fix_parser_delim_detect;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic [2:0]  soh_o;
  logic [2:0]  sep_o;
  logic        tag_status_o;
  logic        value_status_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_multi_o;
  logic [15:0] field_cnt_o;

  fix_parser_delim_detect dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .soh_o          (soh_o),
    .sep_o          (sep_o),
    .tag_status_o   (tag_status_o),
    .value_status_o (value_status_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .err_multi_o    (err_multi_o),
    .field_cnt_o    (field_cnt_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  soh;
    logic [2:0]  sep;
    logic        tag;
    logic        val;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] d, input logic [2:0] soh, input logic [2:0] sep,
                              input logic tag, input logic err, input logic [15:0] cnt);
    exp_t e;
    e.data = d;
    e.soh  = soh;
    e.sep  = sep;
    e.tag  = tag;
    e.val  = !tag;
    e.err  = err;
    e.cnt  = cnt;
    return e;
  endfunction

  // Scoreboard monitor: an output word is consumed on a rising edge where
  // valid_o && ready_i, so sample those at the preceding falling edge.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_output: got data=%h with no word expected", data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_o !== e.data || soh_o !== e.soh || sep_o !== e.sep ||
            tag_status_o !== e.tag || value_status_o !== e.val ||
            err_multi_o !== e.err || field_cnt_o !== e.cnt) begin
          n_miss++;
          $display("FAIL word_%h: got soh=%0d sep=%0d tag=%b val=%b err=%b cnt=%h data=%h, expected soh=%0d sep=%0d tag=%b val=%b err=%b cnt=%h",
                   e.data, soh_o, sep_o, tag_status_o, value_status_o, err_multi_o, field_cnt_o, data_o,
                   e.soh, e.sep, e.tag, e.val, e.err, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Present a word and hold it until accepted (bounded), then drop valid_i.
  task automatic send(input logic [31:0] d, input exp_t e, input bit push);
    int t;
    if (push) exp_q.push_back(e);
    data_i  = d;
    valid_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_o && t < 100);
    if (!ready_o) check("accept_timeout", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  localparam logic [31:0] W_STALL = 32'h41423D43;
  localparam logic [31:0] W_NEXT  = 32'h01414141;

  initial begin
    int t;
    rst     = 1'b1;
    flush_i = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    ready_i = 1'b1;

    // Reset state, sampled while reset is still asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_data_o", data_o, 32'h0);
    check("rst_soh_o", 32'(soh_o), 32'd7);
    check("rst_sep_o", 32'(sep_o), 32'd7);
    check("rst_tag_status", 32'(tag_status_o), 32'd1);
    check("rst_value_status", 32'(value_status_o), 32'd0);
    check("rst_err_multi", 32'(err_multi_o), 32'd0);
    check("rst_field_cnt", 32'(field_cnt_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed words; comments give the parser state after each.
    send(32'h383D4649, mk(32'h383D4649, 3'd7, 3'd2, 1'b1, 1'b0, 16'd0), 1'b1); // VALUE
    send(32'h582E3401, mk(32'h582E3401, 3'd0, 3'd7, 1'b0, 1'b0, 16'd1), 1'b1); // TAG
    send(32'h3D310135, mk(32'h3D310135, 3'd1, 3'd3, 1'b1, 1'b0, 16'd2), 1'b1); // TAG
    send(32'h01410142, mk(32'h01410142, 3'd3, 3'd7, 1'b1, 1'b1, 16'd4), 1'b1); // TAG
    send(32'h3D3D4141, mk(32'h3D3D4141, 3'd7, 3'd3, 1'b1, 1'b1, 16'd4), 1'b1); // VALUE
    send(32'h41414141, mk(32'h41414141, 3'd7, 3'd7, 1'b0, 1'b0, 16'd4), 1'b1); // VALUE
    send(32'h01003D00, mk(32'h01003D00, 3'd3, 3'd1, 1'b0, 1'b0, 16'd5), 1'b1); // VALUE
    send(32'h3D000001, mk(32'h3D000001, 3'd0, 3'd3, 1'b0, 1'b0, 16'd6), 1'b1); // TAG

    // Backpressure: hold a word for 3 cycles while the next one waits.
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    send(W_STALL, mk(W_STALL, 3'd7, 3'd1, 1'b1, 1'b0, 16'd6), 1'b1);        // VALUE
    data_i  = W_NEXT;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid_o", 32'(valid_o), 32'd1);
      check("stall_data_o", data_o, W_STALL);
      check("stall_sep_o", 32'(sep_o), 32'd1);
      check("stall_ready_o", 32'(ready_o), 32'd0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    exp_q.push_back(mk(W_NEXT, 3'd3, 3'd7, 1'b0, 1'b0, 16'd7));             // TAG
    @(negedge clk);
    check("unstall_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during a stall discards the held word.
    ready_i = 1'b0;
    send(32'h01010101, mk(32'h0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall_valid_o", 32'(valid_o), 32'd0);
    check("rst_stall_data_o", data_o, 32'h0);
    check("rst_stall_field_cnt", 32'(field_cnt_o), 32'd0);
    @(posedge clk);
    #1;
    ready_i = 1'b1;

    // Drive the field count up to 16'hFFFE, then across saturation.
    for (int i = 0; i < 16383; i++)
      send(32'h01010101, mk(32'h01010101, 3'd3, 3'd7, 1'b1, 1'b1, 16'(4 * (i + 1))), 1'b1);
    send(32'h01010000, mk(32'h01010000, 3'd3, 3'd7, 1'b1, 1'b1, 16'hFFFE), 1'b1);
    send(32'h01010101, mk(32'h01010101, 3'd3, 3'd7, 1'b1, 1'b1, 16'hFFFF), 1'b1);
    send(32'h01010101, mk(32'h01010101, 3'd3, 3'd7, 1'b1, 1'b1, 16'hFFFF), 1'b1);
    send(32'h41413D41, mk(32'h41413D41, 3'd7, 3'd1, 1'b1, 1'b0, 16'hFFFF), 1'b1); // VALUE

    // Flush together with a valid word: word dropped, count cleared, back to tag.
    data_i  = 32'h41414141;
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid_o", 32'(valid_o), 32'd0);
    check("flush_field_cnt", 32'(field_cnt_o), 32'd0);
    @(posedge clk);
    #1;
    send(32'h41414141, mk(32'h41414141, 3'd7, 3'd7, 1'b1, 1'b0, 16'd0), 1'b1);

    // Drain the scoreboard.
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain_pending_words", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fix_parser_delim_detect.md
FIX_PARSER_DELIM_DETECT -- requirements
Module: fix_parser_delim_detect

Interface
REQ-001 Parameter SOH_CHAR, default 8'h01, field-terminator byte value.
REQ-002 Parameter SEP_CHAR, default 8'h3D ('='), tag/value separator byte value.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, on the ports below.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush_i  in  1  synchronous message abort: return to tag state and drop the held word.
REQ-007 data_i  in  32  raw FIX stream word; byte 3 (bits 31:24) is earliest in the stream, byte 0 (bits 7:0) is latest.
REQ-008 valid_i  in  1  data_i is valid.
REQ-009 ready_o  out  1  block accepts data_i this cycle.
REQ-010 data_o  out  32  registered copy of the accepted word.
REQ-011 soh_o  out  3  byte index (0-3) of the earliest SOH_CHAR in data_o; 3'b111 = none.
REQ-012 sep_o  out  3  byte index (0-3) of the earliest SEP_CHAR in data_o; 3'b111 = none.
REQ-013 tag_status_o  out  1  parser was inside a tag at the start of data_o.
REQ-014 value_status_o  out  1  parser was inside a value at the start of data_o.
REQ-015 valid_o  out  1  output word valid.
REQ-016 ready_i  in  1  downstream consumes the output word.
REQ-017 err_multi_o  out  1  data_o holds more than one SOH_CHAR or more than one SEP_CHAR.
REQ-018 field_cnt_o  out  16  count of SOH_CHAR bytes accepted since reset/flush, saturating.

Function
REQ-019 Single-entry output register, latency 1: word accepted on cycle N appears on the outputs at cycle N+1.
REQ-020 ready_o SHALL equal (!valid_o || ready_i); a word is accepted when valid_i && ready_o.
REQ-021 When valid_o && !ready_i, all outputs SHALL hold unchanged.
REQ-022 On accept without a new word and with ready_i high, valid_o SHALL deassert on the next cycle.
REQ-023 Two-state parse FSM, S_TAG and S_VALUE. Reset and flush state: S_TAG.
REQ-024 The output flags SHALL reflect the FSM state before the word is processed: tag_status_o = (state==S_TAG), value_status_o = (state==S_VALUE).
REQ-025 Index encoding: byte k found at bits [8k+7:8k]. The earliest occurrence is the highest matching index.
REQ-026 FSM update on accept uses the latest delimiter in the word (the lowest matching index over both characters).
- Latest is SOH_CHAR: next state S_TAG.
- Latest is SEP_CHAR: next state S_VALUE.
- No delimiter: state unchanged.
REQ-027 err_multi_o SHALL be asserted with the word when more than one byte matches SOH_CHAR or more than one matches SEP_CHAR. The word is still forwarded, and the FSM still updates per REQ-026.
REQ-028 field_cnt_o SHALL increase by the number of SOH_CHAR bytes (0-4) in each accepted word, saturating at 16'hFFFF. The count updates in the same cycle the word is registered.
REQ-029 If flush_i and an accept occur in the same cycle, flush wins: the word is dropped, valid_o=0, state=S_TAG, field_cnt_o=0.
REQ-030 flush_i SHALL take effect regardless of ready_i.

Reset
REQ-031 While rst is high, on each clock edge: valid_o=0, data_o=0, soh_o=3'b111, sep_o=3'b111, tag_status_o=1, value_status_o=0, err_multi_o=0, field_cnt_o=0, state=S_TAG.
REQ-032 rst SHALL take priority over flush_i and valid_i. Reset mid-stall discards the held word.

Verification
REQ-033 After reset, accept 32'h383D4649 ("8=FI") -> next cycle: soh_o=7, sep_o=2, tag_status_o=1, value_status_o=0, err_multi_o=0. FSM is then S_VALUE.
REQ-034 Then 32'h582E3401 ("X.4",SOH) -> soh_o=0, sep_o=7, value_status_o=1, field_cnt_o=1. FSM is then S_TAG.
REQ-035 32'h3D310135 ("=1",SOH,"5") from S_TAG -> sep_o=3, soh_o=1, tag_status_o=1. The latest delimiter is SOH, so FSM stays S_TAG.
REQ-036 32'h01410142 -> soh_o=3, err_multi_o=1, field_cnt_o increases by 2.
REQ-037 Hold ready_i=0 with valid_o=1 for 3 cycles -> outputs stable and ready_o=0. Raise ready_i -> the next word is accepted the same cycle.
REQ-038 Preload field_cnt_o=16'hFFFE and feed 32'h01010101 -> field_cnt_o=16'hFFFF. Then assert flush_i and valid_i together -> valid_o=0, field_cnt_o=0, tag_status_o=1 on the next word.
